// File: rtl/mnist_image_loader_if.sv
// rtl/mnist_image_loader_if.sv - stream, runner write port and status bundle for the MNIST image loader
interface mnist_image_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       write_enable;
  logic [9:0] write_addr;
  logic [7:0] write_data;
  logic [3:0] digit_in;
  logic [3:0] result_digit;
  logic       result_valid;
  logic       frame_error;
  logic       busy;

  // Loader side
  modport slave (
    input  in_valid, in_data, digit_in,
    output in_ready, write_enable, write_addr, write_data,
           result_digit, result_valid, frame_error, busy
  );

  // Stream source / runner / observer side
  modport master (
    output in_valid, in_data, digit_in,
    input  in_ready, write_enable, write_addr, write_data,
           result_digit, result_valid, frame_error, busy
  );
endinterface

// File: rtl/mnist_image_loader.sv
// rtl/mnist_image_loader.sv - framed byte stream to binarised runner writes, digit report and stall abort
module mnist_image_loader #(
  parameter int         N_PIXELS       = 784,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] THRESHOLD      = 8'd128,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         SETTLE_CYCLES  = 2
) (
  input logic                  clk,
  input logic                  rst,
  mnist_image_loader_if.slave  bus
);
  localparam int ADDR_W = 10;
  localparam int PIX_W  = $clog2(N_PIXELS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_REPORT} state_t;

  state_t              state, state_next;
  logic [PIX_W-1:0]    pix_cnt, pix_cnt_next;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_next;
  logic [SET_W-1:0]    settle_cnt, settle_cnt_next;
  logic                write_enable, write_enable_next;
  logic [ADDR_W-1:0]   write_addr, write_addr_next;
  logic [7:0]          write_data, write_data_next;
  logic [3:0]          result_digit, result_digit_next;
  logic                result_valid, result_valid_next;
  logic                frame_error, frame_error_next;
  logic                in_ready;
  logic                xfer;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign xfer     = bus.in_valid && in_ready;

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state != S_IDLE);
  assign bus.write_enable = write_enable;
  assign bus.write_addr   = write_addr;
  assign bus.write_data   = write_data;
  assign bus.result_digit = result_digit;
  assign bus.result_valid = result_valid;
  assign bus.frame_error  = frame_error;

  // State, counters and registered outputs; reset drops any in-flight write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pix_cnt      <= '0;
      idle_cnt     <= '0;
      settle_cnt   <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      result_digit <= '0;
      result_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_next;
      pix_cnt      <= pix_cnt_next;
      idle_cnt     <= idle_cnt_next;
      settle_cnt   <= settle_cnt_next;
      write_enable <= write_enable_next;
      write_addr   <= write_addr_next;
      write_data   <= write_data_next;
      result_digit <= result_digit_next;
      result_valid <= result_valid_next;
      frame_error  <= frame_error_next;
    end
  end

  // Next-state and next-output decode; strobes default low, write port holds its last value
  always_comb begin
    state_next        = state;
    pix_cnt_next      = pix_cnt;
    idle_cnt_next     = idle_cnt;
    settle_cnt_next   = settle_cnt;
    write_enable_next = 1'b0;
    write_addr_next   = write_addr;
    write_data_next   = write_data;
    result_digit_next = result_digit;
    result_valid_next = 1'b0;
    frame_error_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer && (bus.in_data == SYNC_BYTE)) begin
          state_next    = S_LOAD;
          pix_cnt_next  = '0;
          idle_cnt_next = '0;
        end
      end
      S_LOAD: begin
        // A transfer always wins over a timeout landing in the same cycle
        if (xfer) begin
          write_enable_next = 1'b1;
          write_addr_next   = ADDR_W'(pix_cnt);
          write_data_next   = {7'b0, (bus.in_data >= THRESHOLD)};
          pix_cnt_next      = pix_cnt + PIX_W'(1);
          idle_cnt_next     = '0;
          if (pix_cnt == PIX_W'(N_PIXELS - 1)) begin
            state_next      = S_SETTLE;
            settle_cnt_next = '0;
          end
        end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          state_next       = S_IDLE;
          frame_error_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt + IDLE_W'(1);
        end
      end
      S_SETTLE: begin
        // settle_cnt is 0 in the cycle the final write strobe is on the bus
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_next = S_REPORT;
        end else begin
          settle_cnt_next = settle_cnt + SET_W'(1);
        end
      end
      S_REPORT: begin
        result_digit_next = bus.digit_in;
        result_valid_next = 1'b1;
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mnist_image_loader.sv
// tb/tb_mnist_image_loader.sv - directed self-checking bench for mnist_image_loader
module tb_mnist_image_loader;
  localparam int NPIX    = 784;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mnist_image_loader_if bus();

  mnist_image_loader #(
    .N_PIXELS(NPIX), .SYNC_BYTE(8'hA5), .THRESHOLD(8'd128),
    .TIMEOUT_CYCLES(TIMEOUT), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Runner model: pixel memory plus a registered digit (7 if last pixel set, else 2)
  bit         mem [0:1023];
  logic [3:0] digit_reg = 4'd2;
  always @(posedge clk) begin
    if (bus.write_enable) mem[bus.write_addr] <= bus.write_data[0];
    digit_reg <= mem[NPIX-1] ? 4'd7 : 4'd2;
  end
  assign bus.digit_in = digit_reg;

  // Observer away from the active edge
  int         cyc = 0;
  int         we_addr[$];
  int         we_data[$];
  int         we_cyc[$];
  int         rv_cnt = 0, rv_cyc = 0, fe_cnt = 0, fe_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (bus.write_enable) begin
      we_addr.push_back(int'(bus.write_addr));
      we_data.push_back(int'(bus.write_data));
      we_cyc.push_back(cyc);
    end
    if (bus.result_valid) begin rv_cnt++; rv_cyc = cyc; end
    if (bus.frame_error)  begin fe_cnt++; fe_cyc = cyc; end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin t++; @(negedge clk); end
    if (!bus.in_ready) check("send_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin n++; @(negedge clk); end
  endtask

  task automatic check_seq(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (base + i >= we_addr.size()) bad++;
      else if (we_addr[base+i] != i || we_data[base+i] != exp_q[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, rv0, fe0, n, t;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_we", bus.write_enable, 0);
    check("rst_addr", bus.write_addr, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_digit", bus.result_digit, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_fe", bus.frame_error, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-sync bytes discarded in IDLE, then sync starts a frame
    base = we_addr.size();
    send(8'h00);
    send(8'h17);
    idle(2);
    check("idle_no_write", we_addr.size() - base, 0);
    check("idle_not_busy", bus.busy, 0);
    rv0 = rv_cnt;
    send(8'hA5);
    check("sync_busy", bus.busy, 1);

    // Alternating 0x7F/0x80 frame with embedded 0xA5 pixels, continuous valid
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      b = (i == 5 || i == 10) ? 8'hA5 : ((i % 2) ? 8'h80 : 8'h7F);
      exp_q.push_back((b >= 8'd128) ? 1 : 0);
      send(b);
    end
    wait_ready(n);
    check("f1_settle_not_ready", n, 3);
    check("f1_rv", bus.result_valid, 1);
    check("f1_digit", bus.result_digit, 7);
    idle(5);
    check("f1_write_count", we_addr.size() - base, NPIX);
    check_seq("f1_write_seq", base);
    check("f1_rv_latency", rv_cyc - we_cyc[we_cyc.size()-1], 3);
    check("f1_rv_once", rv_cnt - rv0, 1);
    check("f1_digit_hold", bus.result_digit, 7);
    check("f1_idle", bus.busy, 0);

    // Asynchronous reset mid-frame, right while a write strobe is on the bus
    send(8'hA5);
    send(8'hFF); send(8'hFF); send(8'hFF);
    check("mid_we_before_rst", bus.write_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_we", bus.write_enable, 0);
    check("mid_rst_digit", bus.result_digit, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_addr", bus.write_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Timeout: a transfer on the would-be timeout cycle survives, then silence aborts
    base = we_addr.size(); fe0 = fe_cnt; rv0 = rv_cnt;
    send(8'hA5);
    for (int i = 0; i < 10; i++) send(8'h90);
    idle(TIMEOUT - 1);
    send(8'h10);
    t = cyc;
    check("to_edge_no_abort", fe_cnt - fe0, 0);
    check("to_edge_busy", bus.busy, 1);
    n = 0;
    while (fe_cnt == fe0 && n < 40) begin @(negedge clk); n++; end
    idle(3);
    check("to_fe_once", fe_cnt - fe0, 1);
    check("to_fe_cycle", fe_cyc - t, TIMEOUT + 1);
    check("to_idle", bus.busy, 0);
    check("to_ready", bus.in_ready, 1);
    check("to_writes", we_addr.size() - base, 11);
    check("to_no_rv", rv_cnt - rv0, 0);

    // Next frame after the abort completes normally (all dark pixels -> digit 2)
    base = we_addr.size(); rv0 = rv_cnt;
    send(8'hA5);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin exp_q.push_back(0); send(8'h00); end
    wait_ready(n);
    check("f2_settle_not_ready", n, 3);
    check("f2_rv", bus.result_valid, 1);
    check("f2_digit", bus.result_digit, 2);
    idle(2);
    check_seq("f2_write_seq", base);
    check("f2_rv_once", rv_cnt - rv0, 1);

    // Random gaps below the timeout, then a sync byte held through SETTLE/REPORT
    base = we_addr.size(); rv0 = rv_cnt; fe0 = fe_cnt;
    send(8'hA5);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      idle($urandom_range(0, 6));
      b = (i == NPIX - 1) ? 8'hFF : 8'($urandom_range(0, 255));
      exp_q.push_back((b >= 8'd128) ? 1 : 0);
      send(b);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    wait_ready(n);
    check("f3_held_not_ready", n, 3);
    check("f3_rv", bus.result_valid, 1);
    check("f3_digit", bus.result_digit, 7);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("f3_held_consumed", bus.busy, 1);
    idle(3);
    check("f3_write_count", we_addr.size() - base, NPIX);
    check_seq("f3_write_seq", base);
    check("f3_no_abort", fe_cnt - fe0, 0);
    check("f3_rv_once", rv_cnt - rv0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
